riscv_rf_ctx_sequencer: RTL and testbench
=========================================

RISCV_RF_CTX_SEQUENCER -- requirements
Module: riscv_rf_ctx_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: register-file address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register and memory data width.
REQ-003 SHALL have parameter NUM_REGS, default 16: number of registers; r0 is excluded from transfers.
REQ-004 SHALL have ports clk (in, 1): the single clock; and rst_n (in, 1): asynchronous, active-low reset.
REQ-005 SHALL have ports save_req_i (in, 1) and restore_req_i (in, 1): start a context save or a context restore.
REQ-006 SHALL have ports base_addr_i (in, 32): context-area byte address; busy_o (out, 1); done_o (out, 1): one-cycle completion pulse.
REQ-007 SHALL have register-file ports rf_raddr_o (out, ADDR_WIDTH) and rf_rdata_i (in, DATA_WIDTH), which drive a read port.
REQ-008 SHALL have register-file ports rf_waddr_o (out, ADDR_WIDTH), rf_wdata_o (out, DATA_WIDTH) and rf_we_o (out, 1), which drive the priority write port.
REQ-009 SHALL have memory ports mem_req_o, mem_we_o (out, 1); mem_addr_o (out, 32); mem_wdata_o (out, DATA_WIDTH); mem_gnt_i, mem_rvalid_i (in, 1); mem_rdata_i (in, DATA_WIDTH).

Function
REQ-010 SHALL implement the states IDLE, SAVE_REQ, SAVE_WAIT, REST_REQ, REST_WAIT and DONE.
REQ-011 In IDLE, save_req_i=1 SHALL capture base_addr_i (bits [1:0] forced to 0), set idx=1 and go to SAVE_REQ.
REQ-012 In IDLE, restore_req_i=1 with save_req_i=0 SHALL do the same as REQ-011 but go to REST_REQ; if both are asserted, save wins and the restore is dropped, not queued.
REQ-013 save_req_i and restore_req_i SHALL be ignored in every state except IDLE.
REQ-014 In SAVE_REQ: mem_req_o=1, mem_we_o=1, mem_addr_o=base+4*idx, rf_raddr_o=idx, mem_wdata_o=rf_rdata_i; these are held until mem_gnt_i=1, then the block goes to SAVE_WAIT.
REQ-015 In SAVE_WAIT the block SHALL wait for mem_rvalid_i=1. Then, if idx=NUM_REGS-1 it goes to DONE; otherwise idx increments and it returns to SAVE_REQ.
REQ-016 In REST_REQ: mem_req_o=1, mem_we_o=0, mem_addr_o=base+4*idx, held until mem_gnt_i=1, then the block goes to REST_WAIT.
REQ-017 In REST_WAIT, in the cycle mem_rvalid_i=1: rf_we_o=1, rf_waddr_o=idx, rf_wdata_o=mem_rdata_i (combinational, zero latency). Next state follows the rule of REQ-015.
REQ-018 rf_we_o SHALL be 0 in every other cycle; rf_waddr_o is never 0.
REQ-019 At most one memory transaction SHALL be outstanding; mem_rvalid_i is never expected in the same cycle as the grant.
REQ-020 In DONE, done_o=1 for exactly one cycle, then the block goes to IDLE.
REQ-021 busy_o SHALL be 1 in every state except IDLE.
REQ-022 mem_rvalid_i outside a WAIT state SHALL be ignored.
REQ-023 Address arithmetic SHALL be 32-bit modulo; wrap-around above 0xFFFFFFFC is not flagged.
REQ-024 idx SHALL be $clog2(NUM_REGS) bits wide and SHALL never exceed NUM_REGS-1.

Reset
REQ-025 rst_n=0 SHALL force IDLE immediately, including mid-sequence, with no further memory or register-file traffic.
REQ-026 During reset every output SHALL be 0; a partially written context area is not repaired.

Structure
REQ-027 The shared package riscv_rf_ctx_pkg SHALL hold the state enum and the WORD_BYTES=4 constant.
REQ-028 No sub-module is required: a single FSM plus an idx counter and a base register.

Verification
REQ-029 Save test: NUM_REGS=16, base 0x1000, gnt immediate, rvalid one cycle later -> 15 writes to 0x1004..0x103C with data r1..r15; busy_o high for exactly 31 cycles; one done_o pulse.
REQ-030 Restore test: memory word at 0x2000+4k = 0xA5000000+k -> rf_we_o pulses 15 times and register k = 0xA5000000+k; r0 is never written.
REQ-031 Grant back-pressure: mem_gnt_i withheld 3 cycles on idx=5 -> mem_addr_o, mem_wdata_o and mem_we_o stable throughout; one transaction per register.
REQ-032 Simultaneous start: save_req_i=restore_req_i=1 in IDLE -> a save executes; a restore_req_i pulse mid-save has no effect.
REQ-033 Reset mid-operation: rst_n=0 during REST_WAIT at idx=7 -> outputs 0 at once, busy_o=0, no done_o, and a new save then starts from idx=1.
REQ-034 Unaligned base: base_addr_i=0x3003 -> first address 0x3004.

Source files
------------

// File: rtl/riscv_rf_ctx_pkg.sv
// Shared definitions for the register-file context save/restore sequencer.
package riscv_rf_ctx_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE_REQ,
        ST_SAVE_WAIT,
        ST_REST_REQ,
        ST_REST_WAIT,
        ST_DONE
    } ctx_state_e;

endpackage

// File: rtl/riscv_rf_ctx_sequencer.sv
// Moves registers r1..r(NUM_REGS-1) to or from a word-aligned memory context area,
// one memory transaction at a time.
module riscv_rf_ctx_sequencer
    import riscv_rf_ctx_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  save_req_i,
    input  logic                  restore_req_i,
    input  logic [31:0]           base_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  rf_we_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned      IDX_W    = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    ctx_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      base_q, base_d;
    logic [31:0]      word_addr;

    // Plain 32-bit add: wrap past the top of the address space is intentional.
    assign word_addr = base_q + 32'(idx_q) * WORD_BYTES;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        base_d      = base_q;
        busy_o      = (state_q != ST_IDLE);
        done_o      = 1'b0;
        rf_raddr_o  = '0;
        rf_waddr_o  = '0;
        rf_wdata_o  = '0;
        rf_we_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        case (state_q)
            ST_IDLE: begin
                if (save_req_i || restore_req_i) begin
                    base_d  = base_addr_i & ~32'(WORD_BYTES - 1);
                    idx_d   = IDX_W'(1);
                    state_d = save_req_i ? ST_SAVE_REQ : ST_REST_REQ;
                end
            end
            ST_SAVE_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = word_addr;
                rf_raddr_o  = ADDR_WIDTH'(idx_q);
                mem_wdata_o = rf_rdata_i;
                if (mem_gnt_i) state_d = ST_SAVE_WAIT;
            end
            ST_SAVE_WAIT: begin
                if (mem_rvalid_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SAVE_REQ;
                    end
                end
            end
            ST_REST_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = word_addr;
                if (mem_gnt_i) state_d = ST_REST_WAIT;
            end
            ST_REST_WAIT: begin
                if (mem_rvalid_i) begin
                    rf_we_o    = 1'b1;
                    rf_waddr_o = ADDR_WIDTH'(idx_q);
                    rf_wdata_o = mem_rdata_i;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_REST_REQ;
                    end
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_riscv_rf_ctx_sequencer.sv
// Bench for riscv_rf_ctx_sequencer: register file and memory models plus a per-operation
// reference of the transactions a save or restore must produce.
module tb_riscv_rf_ctx_sequencer;

    localparam int NREG = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        save_req_i = 1'b0;
    logic        restore_req_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic        busy_o, done_o;
    logic [4:0]  rf_raddr_o, rf_waddr_o;
    logic [31:0] rf_rdata_i, rf_wdata_o;
    logic        rf_we_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    riscv_rf_ctx_sequencer #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_REGS(NREG)) dut (
        .clk(clk), .rst_n(rst_n),
        .save_req_i(save_req_i), .restore_req_i(restore_req_i), .base_addr_i(base_addr_i),
        .busy_o(busy_o), .done_o(done_o),
        .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i),
        .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_we_o(rf_we_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } tx_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; } rfw_t;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] rf [NREG];
    logic [31:0] mem [logic [31:0]];
    tx_t         txq [$];
    rfw_t        rfq [$];
    int          busy_cnt, done_cnt;

    // Environment knobs
    bit          rand_mode = 0;
    bit          inject    = 0;
    int          fixed_lat = 1;
    bit          stall_en  = 0;
    logic [31:0] stall_addr = '0;

    // Memory model state
    int          wait_cnt = 0, next_stall = 0, dly = 0;
    bit          pend = 0;
    logic [31:0] pend_data = '0;
    int          stall_need;

    assign rf_rdata_i = rf[rf_raddr_o[3:0]];
    assign stall_need = (stall_en && mem_addr_o == stall_addr) ? 3 : next_stall;
    assign mem_gnt_i  = mem_req_o && (wait_cnt >= stall_need);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    // Monitor plus memory responder: sample at negedge, drive responses just after posedge.
    initial begin
        bit          hold_prev = 0;
        logic [31:0] p_addr = '0, p_wdata = '0;
        logic        p_we = 1'b0;
        forever begin
            bit          n_rv, n_pend;
            logic [31:0] n_rd;
            int          n_dly, n_wait, lat;
            @(negedge clk);
            if (!rst_n) begin
                pend = 0; wait_cnt = 0; mem_rvalid_i = 1'b0; hold_prev = 0;
                continue;
            end
            if (busy_o) busy_cnt++;
            if (done_o) done_cnt++;
            if (rf_we_o) begin
                chk("rf_waddr_nonzero", 32'(rf_waddr_o != 0), 32'd1);
                rfq.push_back('{addr: rf_waddr_o, data: rf_wdata_o});
                rf[rf_waddr_o[3:0]] = rf_wdata_o;
            end
            if (hold_prev) begin
                chk("hold_req",   32'(mem_req_o), 32'd1);
                chk("hold_addr",  mem_addr_o, p_addr);
                chk("hold_we",    32'(mem_we_o), 32'(p_we));
                chk("hold_wdata", mem_wdata_o, p_wdata);
            end
            hold_prev = mem_req_o && !mem_gnt_i;
            p_addr = mem_addr_o; p_we = mem_we_o; p_wdata = mem_wdata_o;

            n_rv = 0; n_rd = mem_rdata_i; n_pend = pend; n_dly = dly; n_wait = wait_cnt;
            if (pend) begin
                if (dly <= 1) begin n_rv = 1; n_rd = pend_data; n_pend = 0; end
                else n_dly = dly - 1;
            end else if (inject && !busy_o && $urandom_range(0, 3) == 0) begin
                n_rv = 1; n_rd = $urandom;
            end
            if (mem_req_o) begin
                if (mem_gnt_i) begin
                    txq.push_back('{we: mem_we_o, addr: mem_addr_o, data: mem_wdata_o});
                    if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
                    lat = rand_mode ? int'($urandom_range(1, 3)) : fixed_lat;
                    pend_data = mem_we_o ? 32'h0 : mem_rd(mem_addr_o);
                    if (lat == 1) begin n_rv = 1; n_rd = pend_data; end
                    else begin n_pend = 1; n_dly = lat - 1; end
                    n_wait = -1;
                end else begin
                    n_wait = wait_cnt + 1;
                end
            end
            @(posedge clk);
            #1;
            if (rst_n) begin
                mem_rvalid_i = n_rv; mem_rdata_i = n_rd; pend = n_pend; dly = n_dly;
                if (n_wait < 0) begin
                    wait_cnt = 0;
                    next_stall = rand_mode ? int'($urandom_range(0, 2)) : 0;
                end else begin
                    wait_cnt = n_wait;
                end
            end
        end
    end

    task automatic start_op(input bit s, input bit r, input logic [31:0] base);
        @(negedge clk); #2;
        txq.delete(); rfq.delete(); busy_cnt = 0; done_cnt = 0;
        save_req_i = s; restore_req_i = r; base_addr_i = base;
        @(negedge clk); #2;
        save_req_i = 0; restore_req_i = 0; base_addr_i = $urandom;
    endtask

    // Reference: a save writes rf[k] to aligned_base+4k, a restore loads mem[aligned_base+4k] into rk.
    task automatic run_op(input bit s, input bit r, input logic [31:0] base,
                          input int exp_busy, input bit mid_pulse);
        logic [31:0] rf_pre [NREG];
        logic [31:0] exp_ld [NREG];
        logic [31:0] ab, a;
        int cyc;
        ab = base & 32'hFFFF_FFFC;
        for (int k = 0; k < NREG; k++) begin
            rf_pre[k] = rf[k];
            a = ab + 32'(4 * k);
            exp_ld[k] = mem_rd(a);
        end
        start_op(s, r, base);
        cyc = 0;
        while (done_cnt == 0 && cyc < 2000) begin
            @(negedge clk); #2;
            cyc++;
            restore_req_i = (mid_pulse && cyc == 8);
        end
        restore_req_i = 0;
        chk("op_timeout", 32'(cyc < 2000), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        chk("busy_after", 32'(busy_o), 32'd0);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        if (exp_busy >= 0) chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        chk("n_mem_tx", 32'(txq.size()), 32'(NREG - 1));
        for (int k = 1; k < NREG; k++) begin
            if (k <= txq.size()) begin
                a = ab + 32'(4 * k);
                chk("tx_we",   32'(txq[k-1].we), 32'(s));
                chk("tx_addr", txq[k-1].addr, a);
                if (s) chk("tx_wdata", txq[k-1].data, rf_pre[k]);
            end
        end
        chk("n_rf_writes", 32'(rfq.size()), s ? 32'd0 : 32'(NREG - 1));
        for (int k = 1; k < NREG; k++) begin
            if (!s && k <= rfq.size()) begin
                chk("rfw_addr", 32'(rfq[k-1].addr), 32'(k));
                chk("rfw_data", rfq[k-1].data, exp_ld[k]);
            end
        end
        chk("r0_untouched", rf[0], rf_pre[0]);
    endtask

    initial begin
        int cyc;
        logic [31:0] b;
        for (int k = 0; k < NREG; k++) rf[k] = $urandom;

        repeat (3) @(negedge clk);
        chk("reset_outs_zero", 32'(|{mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rf_raddr_o,
                                   rf_waddr_o, rf_wdata_o, rf_we_o, busy_o, done_o}), 32'd0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy_o), 32'd0);

        // Plain save: immediate grant, rvalid one cycle later
        run_op(1, 0, 32'h0000_1000, 31, 0);

        // Restore from a known pattern
        for (int k = 0; k < NREG; k++) mem[32'h2000 + 32'(4 * k)] = 32'hA500_0000 + 32'(k);
        run_op(0, 1, 32'h0000_2000, 31, 0);
        for (int k = 1; k < NREG; k++) chk("restored_reg", rf[k], 32'hA500_0000 + 32'(k));

        // Grant withheld three cycles on idx=5
        stall_en = 1; stall_addr = 32'h4000 + 32'd20;
        run_op(1, 0, 32'h0000_4000, 34, 0);
        stall_en = 0;

        // Both requests at once, then a stray restore pulse mid-save
        run_op(1, 1, 32'h0000_1100, 31, 1);

        // Reset during REST_WAIT of idx=7
        fixed_lat = 3;
        start_op(0, 1, 32'h0000_5000);
        cyc = 0;
        while (!(txq.size() == 7 && busy_o && !mem_req_o) && cyc < 500) begin
            @(negedge clk); #2; cyc++;
        end
        chk("reach_idx7_wait", 32'(cyc < 500), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_outs_zero", 32'(|{mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rf_raddr_o,
                                      rf_waddr_o, rf_wdata_o, rf_we_o, busy_o, done_o}), 32'd0);
        chk("midreset_busy", 32'(busy_o), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_no_done", 32'(done_cnt), 32'd0);
        chk("midreset_rf_writes", 32'(rfq.size()), 32'd6);
        chk("midreset_tx_count", 32'(txq.size()), 32'd7);
        fixed_lat = 1;
        run_op(1, 0, 32'h0000_6000, 31, 0);

        // Unaligned base
        run_op(1, 0, 32'h0000_3003, 31, 0);
        if (txq.size() > 0) chk("unaligned_first", txq[0].addr, 32'h0000_3004);
        else chk("unaligned_first", 32'hFFFF_FFFF, 32'h0000_3004);

        // Address wrap past the top of memory
        run_op(0, 1, 32'hFFFF_FFF0, 31, 0);

        // Randomised latency, stalls, stray rvalid, random ops
        rand_mode = 1; inject = 1;
        for (int i = 0; i < 10; i++) begin
            bit s, r;
            s = 1'($urandom_range(0, 1));
            r = !s || 1'($urandom_range(0, 1));
            b = (i % 3 == 2) ? 32'h0000_1000 : $urandom;
            run_op(s, r, b, -1, 0);
        end
        rand_mode = 0; inject = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=%0d exp=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
